// File: rtl/queue_alloc_pkg.sv
// queue_alloc_pkg
//   Shared helpers for the queue enqueue-slot scheduler:
//   - req_idx_w / cnt_width : width helpers for requester index and occupancy
//   - min_int               : integer minimum used for the grant limit
//   - req_idx_t             : requester index type for the default 4-requester build
package queue_alloc_pkg;

  localparam int NumReqDefault = 4;

  typedef logic [$clog2(NumReqDefault)-1:0] req_idx_t;

  function automatic int req_idx_w(input int num_req);
    return $clog2(num_req);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/queue_alloc_scheduler_rr_multi_picker.sv
// rr_multi_picker
//   Pure combinational circular scan: starting at start_idx, grants the first
//   `limit` valid requesters in order start_idx, start_idx+1, ... mod NumReq.
//   The k-th grant lands in slot k.
// Ports:
//   valid      in  NumReq          requester valid vector
//   start_idx  in  ReqIdxW         highest-priority requester
//   limit      in  LimW            maximum grants this cycle (0..EnqWidth)
//   grant_mask out NumReq          one bit per granted requester
//   slot_idx   out EnqWidth x ReqIdxW  requester index per slot, 0 when unused
//   grant_cnt  out LimW            number of grants issued
//   last_idx   out ReqIdxW         index of the last granted requester
module rr_multi_picker
  import queue_alloc_pkg::*;
#(
  parameter int NumReq   = 4,
  parameter int EnqWidth = 2,
  localparam int ReqIdxW = req_idx_w(NumReq),
  localparam int LimW    = $clog2(EnqWidth + 1)
) (
  input  logic [NumReq-1:0]                 valid,
  input  logic [ReqIdxW-1:0]                start_idx,
  input  logic [LimW-1:0]                   limit,
  output logic [NumReq-1:0]                 grant_mask,
  output logic [EnqWidth-1:0][ReqIdxW-1:0]  slot_idx,
  output logic [LimW-1:0]                   grant_cnt,
  output logic [ReqIdxW-1:0]                last_idx
);

  always_comb begin
    int n;
    int j;
    grant_mask = '0;
    slot_idx   = '0;
    last_idx   = start_idx;
    n          = 0;
    j          = 0;
    for (int i = 0; i < NumReq; i++) begin
      j = int'(start_idx) + i;
      if (j >= NumReq) j = j - NumReq;
      if (valid[j] && (n < int'(limit))) begin
        grant_mask[j] = 1'b1;
        // Fixed-index slot write avoids a variable array index.
        for (int k = 0; k < EnqWidth; k++) begin
          if (k == n) slot_idx[k] = ReqIdxW'(j);
        end
        last_idx = ReqIdxW'(j);
        n        = n + 1;
      end
    end
    grant_cnt = LimW'(n);
  end

endmodule

// File: rtl/queue_alloc_scheduler.sv
// queue_alloc_scheduler
//   Shares the EnqWidth enqueue slots of a circular queue among NumReq
//   requesters with multi-grant round-robin, tracking occupancy so that no
//   more entries are granted than the queue has free.
// Ports:
//   clk          in   clock
//   rstn         in   synchronous active-low reset
//   req_valid_i  in   NumReq per-requester enqueue request
//   req_ready_o  out  NumReq grant (transfer on valid && ready)
//   enq_fire_o   out  EnqWidth slot fires, contiguous from bit 0
//   enq_sel_o    out  EnqWidth*ReqIdxW requester index per slot (0 if idle)
//   deq_fire_i   in   DeqWidth dequeue fires from the consumer
//   flush_i      in   empties the queue, blocks grants that cycle
//   count_o      out  CntWidth registered occupancy
//   full_o       out  count_o == Depth
//   empty_o      out  count_o == 0
// Build option:
//   QUEUE_ALLOC_SCHED_DEQ_BYPASS_EN - same-cycle dequeues add to free space,
//   creating a deq_fire_i -> req_ready_o combinational path.
module queue_alloc_scheduler
  import queue_alloc_pkg::*;
#(
  parameter int Depth    = 8,
  parameter int NumReq   = 4,
  parameter int EnqWidth = 2,
  parameter int DeqWidth = 2,
  localparam int ReqIdxW  = req_idx_w(NumReq),
  localparam int CntWidth = cnt_width(Depth),
  localparam int LimW     = $clog2(EnqWidth + 1)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  output logic [EnqWidth-1:0]           enq_fire_o,
  output logic [EnqWidth*ReqIdxW-1:0]   enq_sel_o,
  input  logic [DeqWidth-1:0]           deq_fire_i,
  input  logic                          flush_i,
  output logic [CntWidth-1:0]           count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int CntP1 = CntWidth + 1;

  logic [CntWidth-1:0]                count_q;
  logic [ReqIdxW-1:0]                 rr_ptr_q;
  logic [LimW-1:0]                    grant_limit;
  logic [NumReq-1:0]                  grant_mask;
  logic [EnqWidth-1:0][ReqIdxW-1:0]   slot_idx;
  logic [LimW-1:0]                    grant_cnt;
  logic [ReqIdxW-1:0]                 last_idx;
  logic [CntP1-1:0]                   enq_cnt;
  logic [CntP1-1:0]                   deq_cnt;
  logic [CntP1-1:0]                   count_sum;
  logic [CntWidth-1:0]                count_d;

  // Popcounts of the dequeue and enqueue fire vectors.
  always_comb begin
    deq_cnt = '0;
    for (int k = 0; k < DeqWidth; k++) begin
      deq_cnt = deq_cnt + CntP1'(deq_fire_i[k]);
    end
    enq_cnt = '0;
    for (int k = 0; k < EnqWidth; k++) begin
      enq_cnt = enq_cnt + CntP1'(enq_fire_o[k]);
    end
  end

  always_comb begin
    int free_i;
    free_i = Depth - int'(count_q);
`ifdef QUEUE_ALLOC_SCHED_DEQ_BYPASS_EN
    free_i = free_i + int'(deq_cnt);
`endif
    if (free_i < 0) free_i = 0;
    if (flush_i) grant_limit = '0;
    else         grant_limit = LimW'(min_int(EnqWidth, free_i));
  end

  rr_multi_picker #(
    .NumReq   (NumReq),
    .EnqWidth (EnqWidth)
  ) u_picker (
    .valid      (req_valid_i),
    .start_idx  (rr_ptr_q),
    .limit      (grant_limit),
    .grant_mask (grant_mask),
    .slot_idx   (slot_idx),
    .grant_cnt  (grant_cnt),
    .last_idx   (last_idx)
  );

  always_comb begin
    req_ready_o = grant_mask;
    enq_fire_o  = '0;
    enq_sel_o   = '0;
    for (int k = 0; k < EnqWidth; k++) begin
      enq_fire_o[k]                  = (k < int'(grant_cnt));
      enq_sel_o[k*ReqIdxW +: ReqIdxW] = slot_idx[k];
    end
  end

  // Illegal over-dequeue saturates at zero rather than wrapping.
  always_comb begin
    count_sum = {1'b0, count_q} + enq_cnt;
    if (flush_i)                   count_d = '0;
    else if (count_sum < deq_cnt)  count_d = '0;
    else                           count_d = CntWidth'(count_sum - deq_cnt);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (|grant_mask) begin
        rr_ptr_q <= (last_idx == ReqIdxW'(NumReq - 1)) ? '0 : last_idx + ReqIdxW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && !flush_i) begin
      assert ({1'b0, count_q} >= deq_cnt)
        else $warning("dequeue underflow: deq_cnt=%0d count=%0d, occupancy held at zero",
                      deq_cnt, count_q);
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CntWidth'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: tb/tb_queue_alloc_scheduler.sv
module tb_queue_alloc_scheduler;

  logic       clk;
  logic       rstn;
  logic [3:0] req_valid_i;
  logic [3:0] req_ready_o;
  logic [1:0] enq_fire_o;
  logic [3:0] enq_sel_o;
  logic [1:0] deq_fire_i;
  logic       flush_i;
  logic [3:0] count_o;
  logic       full_o;
  logic       empty_o;

  queue_alloc_scheduler #(
    .Depth(8), .NumReq(4), .EnqWidth(2), .DeqWidth(2)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .enq_fire_o  (enq_fire_o),
    .enq_sel_o   (enq_sel_o),
    .deq_fire_i  (deq_fire_i),
    .flush_i     (flush_i),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] ready;
    logic [1:0] fire;
    logic [3:0] sel;
    int         count;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Monitor: outputs are combinational, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, ".ready"}, int'(req_ready_o), int'(e.ready));
        chk({e.name, ".fire"},  int'(enq_fire_o),  int'(e.fire));
        chk({e.name, ".sel"},   int'(enq_sel_o),   int'(e.sel));
        chk({e.name, ".count"}, int'(count_o),     e.count);
        chk({e.name, ".full"},  int'(full_o),      (e.count == 8) ? 1 : 0);
        chk({e.name, ".empty"}, int'(empty_o),     (e.count == 0) ? 1 : 0);
      end
    end
  end

  task automatic step(input string name, input logic rst_n, input logic [3:0] valid,
                      input logic [1:0] deq, input logic flush,
                      input logic [3:0] e_ready, input logic [1:0] e_fire,
                      input logic [3:0] e_sel, input int e_count);
    exp_t e;
    @(posedge clk);
    #1;
    rstn        = rst_n;
    req_valid_i = valid;
    deq_fire_i  = deq;
    flush_i     = flush;
    e.name  = name;
    e.ready = e_ready;
    e.fire  = e_fire;
    e.sel   = e_sel;
    e.count = e_count;
    sb.push_back(e);
  endtask

  initial begin
    rstn = 1'b0; req_valid_i = '0; deq_fire_i = '0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    //    name      rstn valid    deq    fl    ready    fire   sel      count
    step("rst",    0, 4'b0000, 2'b00, 0, 4'b0000, 2'b00, 4'b0000, 0);
    step("all_a",  1, 4'b1111, 2'b00, 0, 4'b0011, 2'b11, 4'b0100, 0);
    step("all_b",  1, 4'b1111, 2'b00, 0, 4'b1100, 2'b11, 4'b1110, 2);
    step("all_c",  1, 4'b1111, 2'b00, 0, 4'b0011, 2'b11, 4'b0100, 4);
    step("one_r2", 1, 4'b0100, 2'b00, 0, 4'b0100, 2'b01, 4'b0010, 6);
    step("lim1",   1, 4'b1111, 2'b00, 0, 4'b1000, 2'b01, 4'b0011, 7);
    step("full",   1, 4'b1111, 2'b00, 0, 4'b0000, 2'b00, 4'b0000, 8);
    step("fulldq", 1, 4'b1111, 2'b01, 0, 4'b0000, 2'b00, 4'b0000, 8);
    step("refill", 1, 4'b1111, 2'b00, 0, 4'b0001, 2'b01, 4'b0000, 7);
    step("deq2",   1, 4'b0000, 2'b11, 0, 4'b0000, 2'b00, 4'b0000, 8);
    step("deq1",   1, 4'b0000, 2'b01, 0, 4'b0000, 2'b00, 4'b0000, 6);
    step("flush",  1, 4'b0110, 2'b11, 1, 4'b0000, 2'b00, 4'b0000, 5);
    step("rrhold", 1, 4'b0110, 2'b00, 0, 4'b0110, 2'b11, 4'b1001, 0);
    step("r3_a",   1, 4'b1000, 2'b00, 0, 4'b1000, 2'b01, 4'b0011, 2);
    step("r3_wrap",1, 4'b1000, 2'b00, 0, 4'b1000, 2'b01, 4'b0011, 3);
    step("r0r3",   1, 4'b1001, 2'b00, 0, 4'b1001, 2'b11, 4'b1100, 4);
    step("midrst", 0, 4'b0110, 2'b00, 0, 4'b0110, 2'b11, 4'b1001, 6);
    step("undflw", 1, 4'b0000, 2'b01, 0, 4'b0000, 2'b00, 4'b0000, 0);
    step("postrst",1, 4'b1010, 2'b00, 0, 4'b1010, 2'b11, 4'b1101, 0);
    step("enqdeq", 1, 4'b0001, 2'b01, 0, 4'b0001, 2'b01, 4'b0000, 2);
    step("final",  1, 4'b0000, 2'b00, 0, 4'b0000, 2'b00, 4'b0000, 2);
    begin : drain
      int budget;
      budget = 20;
      while (sb.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      n_checks++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
